// File: rtl/rsa_frame_initiator_pkg.sv
// Shared definitions for the RSA frame initiator: FSM encoding, frame layout
// and counter sizing.
package rsa_frame_initiator_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SEND   = 2'd1;
    localparam logic [1:0] ST_RECV   = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

    localparam int WORD_KEY    = 0;
    localparam int WORD_MOD    = 1;
    localparam int WORD_TEXT   = 2;
    localparam int FRAME_WORDS = 3;

    // Bits needed for a counter that runs 0..n-1 (never narrower than one bit).
    function automatic int cnt_width(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/rsa_frame_initiator_byte_word_packer.sv
// Byte-granular shift register: parallel load, shift out at the MSB end while
// shifting a new byte in at the LSB end.
module byte_word_packer
    import rsa_frame_initiator_pkg::*;
#(
    parameter int Width    = 32,
    parameter int OutWidth = Width
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                load_i,
    input  logic [Width-1:0]    load_data_i,
    input  logic                shift_i,
    input  logic [7:0]          byte_i,
    output logic [OutWidth-1:0] top_o
);
    logic [Width-1:0] word_q;
    logic [Width-1:0] word_d;

    // Load wins over shift; a shift drops the top byte and appends byte_i.
    always_comb begin
        word_d = word_q;
        if (load_i) begin
            word_d = load_data_i;
        end else if (shift_i) begin
            word_d = (word_q << 4'd8) | Width'(byte_i);
        end else begin
            word_d = word_q;
        end
    end

    // Storage register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign top_o = word_q[Width-1 -: OutWidth];

endmodule

// File: rtl/rsa_frame_initiator.sv
// Reader-side RSA frame initiator: streams key/mod/plaintext bytes into the UART
// TX FIFO and reassembles the ciphertext word popped from the UART RX FIFO.
module rsa_frame_initiator
    import rsa_frame_initiator_pkg::*;
#(
    parameter int WordSize      = 32,
    parameter int TimeoutCycles = 1000000
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                start_i,
    input  logic [WordSize-1:0] key_i,
    input  logic [WordSize-1:0] mod_i,
    input  logic [WordSize-1:0] plaintext_i,
    output logic [7:0]          tx_data_o,
    output logic                tx_wr_o,
    input  logic                tx_full_i,
    input  logic [7:0]          rx_data_i,
    output logic                rx_rd_o,
    input  logic                rx_empty_i,
    output logic [WordSize-1:0] result_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                timeout_o
);
    localparam int NumBytes = WordSize / 8;
    localparam int TxBytes  = FRAME_WORDS * NumBytes;
    localparam int TxWidth  = FRAME_WORDS * WordSize;
    localparam int TxCntW   = cnt_width(TxBytes);
    localparam int RxCntW   = cnt_width(NumBytes);
    localparam int ToCntW   = cnt_width(TimeoutCycles);
    localparam logic [TxCntW-1:0] TxLast = TxCntW'(TxBytes - 1);
    localparam logic [RxCntW-1:0] RxLast = RxCntW'(NumBytes - 1);
    localparam logic [ToCntW-1:0] ToLast = ToCntW'(TimeoutCycles - 1);

    logic [1:0]          state_q,  state_d;
    logic [TxCntW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [RxCntW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [ToCntW-1:0]   to_cnt_q, to_cnt_d;
    logic [WordSize-1:0] result_q, result_d;
    logic [TxWidth-1:0]  frame_s;
    logic [WordSize-1:0] rx_word_s;
    logic                load_s;
    logic                tx_wr_s;
    logic                rx_rd_s;
    logic                timeout_s;

    // Place the first-transmitted word in the top bits of the frame.
    always_comb begin
        frame_s = '0;
        frame_s[(FRAME_WORDS-1-WORD_KEY)*WordSize  +: WordSize] = key_i;
        frame_s[(FRAME_WORDS-1-WORD_MOD)*WordSize  +: WordSize] = mod_i;
        frame_s[(FRAME_WORDS-1-WORD_TEXT)*WordSize +: WordSize] = plaintext_i;
    end

    // Sequencing: IDLE -> SEND -> RECV -> FINISH, with timeout back to IDLE.
    always_comb begin
        state_d   = state_q;
        tx_cnt_d  = tx_cnt_q;
        rx_cnt_d  = rx_cnt_q;
        to_cnt_d  = to_cnt_q;
        result_d  = result_q;
        load_s    = 1'b0;
        tx_wr_s   = 1'b0;
        rx_rd_s   = 1'b0;
        timeout_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    load_s   = 1'b1;
                    tx_cnt_d = '0;
                    rx_cnt_d = '0;
                    to_cnt_d = '0;
                    state_d  = ST_SEND;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (!tx_full_i) begin
                    tx_wr_s  = 1'b1;
                    tx_cnt_d = tx_cnt_q + TxCntW'(1);
                    if (tx_cnt_q == TxLast) begin
                        state_d = ST_RECV;
                    end else begin
                        state_d = ST_SEND;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_RECV: begin
                if (!rx_empty_i) begin
                    rx_rd_s  = 1'b1;
                    rx_cnt_d = rx_cnt_q + RxCntW'(1);
                    to_cnt_d = '0;
                    if (rx_cnt_q == RxLast) begin
                        // Capture the completed word now so result is valid during FINISH.
                        result_d = (rx_word_s << 4'd8) | WordSize'(rx_data_i);
                        state_d  = ST_FINISH;
                    end else begin
                        state_d  = ST_RECV;
                    end
                end else if (to_cnt_q == ToLast) begin
                    timeout_s = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    to_cnt_d  = to_cnt_q + ToCntW'(1);
                    state_d   = ST_RECV;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
            to_cnt_q <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;
            to_cnt_q <= to_cnt_d;
            result_q <= result_d;
        end
    end

    byte_word_packer #(
        .Width    (TxWidth),
        .OutWidth (8)
    ) u_tx_packer (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .load_i      (load_s),
        .load_data_i (frame_s),
        .shift_i     (tx_wr_s),
        .byte_i      (8'h00),
        .top_o       (tx_data_o)
    );

    // Cleared at start so a timed-out partial response never leaks into the next word.
    byte_word_packer #(
        .Width    (WordSize),
        .OutWidth (WordSize)
    ) u_rx_packer (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .load_i      (load_s),
        .load_data_i ({WordSize{1'b0}}),
        .shift_i     (rx_rd_s),
        .byte_i      (rx_data_i),
        .top_o       (rx_word_s)
    );

    assign tx_wr_o   = tx_wr_s;
    assign rx_rd_o   = rx_rd_s;
    assign timeout_o = timeout_s;
    assign busy_o    = (state_q != ST_IDLE);
    assign done_o    = (state_q == ST_FINISH);
    assign result_o  = result_q;

endmodule

// File: tb/tb_rsa_frame_initiator.sv
// Directed, table-driven bench for rsa_frame_initiator with a cycle-level
// TX recorder and RX FIFO responder.
module tb_rsa_frame_initiator;

    typedef struct {
        logic [31:0] key;
        logic [31:0] modv;
        logic [31:0] pt;
        logic [31:0] resp;
        int          nbytes;
        int          gap;
        int          full_lo;
        int          full_hi;
        int          full_extra;
        int          restart_a;
        int          restart_b;
        int          tail;
        int          abort_after;
        int          exp_done;
        int          exp_to;
        logic [31:0] exp_result;
        int          exp_pops;
    } frame_vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] key;
    logic [31:0] modv;
    logic [31:0] plaintext;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        tx_full;
    logic [7:0]  rx_data;
    logic        rx_rd;
    logic        rx_empty;
    logic [31:0] result;
    logic        busy;
    logic        done;
    logic        timeout;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rsa_frame_initiator #(
        .WordSize      (32),
        .TimeoutCycles (16)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .start_i     (start),
        .key_i       (key),
        .mod_i       (modv),
        .plaintext_i (plaintext),
        .tx_data_o   (tx_data),
        .tx_wr_o     (tx_wr),
        .tx_full_i   (tx_full),
        .rx_data_i   (rx_data),
        .rx_rd_o     (rx_rd),
        .rx_empty_i  (rx_empty),
        .result_o    (result),
        .busy_o      (busy),
        .done_o      (done),
        .timeout_o   (timeout)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Runs one frame: cycle 0 is the start cycle; inputs driven #1 after the
    // rising edge, outputs sampled on the falling edge.
    task automatic run_frame(input string tag, input frame_vec_t v);
        logic [95:0] frame;
        logic [7:0]  q[$];
        int          wait_n, ntx, nrx, done_cnt, done_cyc, to_cyc, end_cyc;
        bit          overlap, finished;
        logic        busy0, busy1;
        frame = {v.key, v.modv, v.pt};
        q.delete();
        for (int i = 0; i < v.nbytes; i++) begin
            if (i < 4) q.push_back(v.resp[31-8*i -: 8]);
            else       q.push_back(8'h99);
        end
        wait_n = 0; ntx = 0; nrx = 0; done_cnt = 0;
        done_cyc = -1; to_cyc = -1; end_cyc = -1;
        overlap = 1'b0; finished = 1'b0; busy0 = 1'b0; busy1 = 1'b0;
        for (int c = 0; c < 100 && !finished; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                key = v.key; modv = v.modv; plaintext = v.pt;
            end
            start   = (c == 0) || (c == v.restart_a) || (c == v.restart_b);
            tx_full = ((c >= v.full_lo) && (c <= v.full_hi)) || (c == v.full_extra);
            if (q.size() == 0) begin
                rx_empty = 1'b1; rx_data = 8'h00;
            end else if (wait_n > 0) begin
                rx_empty = 1'b1; rx_data = 8'h00; wait_n--;
            end else begin
                rx_empty = 1'b0; rx_data = q[0];
            end
            @(negedge clk);
            if (c == 0) busy0 = busy;
            if (c == 1) busy1 = busy;
            if (tx_wr) begin
                if (ntx < 12)
                    check($sformatf("%s_tx_byte%0d", tag, ntx), 64'(tx_data), 64'(frame[95-8*ntx -: 8]));
                ntx++;
            end
            if (rx_rd) begin
                if (q.size() > 0) void'(q.pop_front());
                nrx++;
                if (nrx == 2) wait_n = v.gap;
            end
            if ((tx_wr && rx_rd) || (done && timeout)) overlap = 1'b1;
            if (done) begin done_cnt++; done_cyc = c; end
            if (timeout) to_cyc = c;
            if ((done || timeout) && end_cyc < 0) end_cyc = c;
            if (end_cyc >= 0 && c >= end_cyc + v.tail) finished = 1'b1;
            if (v.abort_after > 0 && ntx == v.abort_after) finished = 1'b1;
        end
        start = 1'b0;
        if (v.abort_after > 0) begin
            check({tag, "_bytes_before_abort"}, 64'(ntx), 64'(v.abort_after));
        end else begin
            check({tag, "_busy_c0"},    64'(busy0),    64'(0));
            check({tag, "_busy_c1"},    64'(busy1),    64'(1));
            check({tag, "_tx_count"},   64'(ntx),      64'(12));
            check({tag, "_rx_pops"},    64'(nrx),      64'(v.exp_pops));
            check({tag, "_done_cyc"},   64'(done_cyc), 64'(v.exp_done));
            check({tag, "_to_cyc"},     64'(to_cyc),   64'(v.exp_to));
            check({tag, "_done_count"}, 64'(done_cnt), 64'((v.exp_done >= 0) ? 1 : 0));
            check({tag, "_result"},     64'(result),   64'(v.exp_result));
            check({tag, "_overlap"},    64'(overlap),  64'(0));
            if (v.tail > 0) check({tag, "_busy_end"}, 64'(busy), 64'(0));
        end
    endtask

    initial begin
        frame_vec_t vecs[6];
        frame_vec_t f;
        reset = 1'b1; start = 1'b0; key = '0; modv = '0; plaintext = '0;
        tx_full = 1'b0; rx_data = 8'h00; rx_empty = 1'b1;

        //        key           mod           text          resp          nb gap flo fhi fx  ra  rb tail ab done to  result       pops
        vecs[0] = '{32'h00000007, 32'h0000008F, 32'h00000041, 32'hDEADBEEF, 5, 0, -1, -1, -1, -1, -1, 3, 0, 17, -1, 32'hDEADBEEF, 4};
        vecs[1] = '{32'h00000007, 32'h0000008F, 32'h00000041, 32'h01020304, 4, 0,  3,  6, 10, -1, -1, 1, 0, 22, -1, 32'h01020304, 4};
        vecs[2] = '{32'h01234567, 32'h89ABCDEF, 32'hFFFFFFFF, 32'h12345678, 4, 0, -1, -1, -1,  5, 14, 3, 0, 17, -1, 32'h12345678, 4};
        vecs[3] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 32'h00FF00FF, 32'hCAFEF00D, 4, 15, -1, -1, -1, -1, -1, 1, 0, 32, -1, 32'hCAFEF00D, 4};
        vecs[4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'hBAADF00D, 2, 0, -1, -1, -1, -1, -1, 2, 0, -1, 30, 32'hCAFEF00D, 2};
        vecs[5] = '{32'h0A0B0C0D, 32'h10203040, 32'h7F7F7F7F, 32'h600DCAFE, 4, 0, -1, -1, -1, -1, -1, 1, 0, 17, -1, 32'h600DCAFE, 4};

        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 64'({tx_data, tx_wr, rx_rd, result, busy, done, timeout}), 64'(0));
        reset = 1'b0;

        for (int i = 0; i < 6; i++) run_frame($sformatf("vec%0d", i), vecs[i]);

        // Reset after five bytes of a frame, then a clean frame from the first key byte.
        f = '{32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4, 32'h00000000, 4, 0, -1, -1, -1, -1, -1, 0, 5, -1, -1, 32'h0, 0};
        run_frame("abort", f);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("midsend_reset_outputs", 64'({tx_data, tx_wr, rx_rd, result, busy, done, timeout}), 64'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        f = '{32'h00000007, 32'h0000008F, 32'h00000041, 32'h0F1E2D3C, 4, 0, -1, -1, -1, -1, -1, 1, 0, 17, -1, 32'h0F1E2D3C, 4};
        run_frame("after_reset", f);

        // Back-to-back: second start lands in the cycle right after done.
        f = '{32'h00000003, 32'h000000BB, 32'h00000022, 32'h0BADBEEF, 4, 0, -1, -1, -1, -1, -1, 0, 0, 17, -1, 32'h0BADBEEF, 4};
        run_frame("b2b_first", f);
        f = '{32'h87654321, 32'hFEDCBA98, 32'h00C0FFEE, 32'h13579BDF, 4, 0, -1, -1, -1, -1, -1, 1, 0, 17, -1, 32'h13579BDF, 4};
        run_frame("b2b_second", f);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
